// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial word comparator.
//   cmp_state_t     : word-assembly FSM state
//   cmp_flags_t     : registered lt/eq/gt verdict
//   CMP_FLAGS_RESET : verdict value after reset (equal)
package serial_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } cmp_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

    localparam cmp_flags_t CMP_FLAGS_RESET = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

endpackage : serial_cmp_pkg

// File: rtl/serial_cmp_digit_step.sv
// One digit step of the serial comparison (combinational).
//   first            : this digit starts a new word; prev_* are ignored
//   a, b             : current digits (already sign-adjusted by the caller)
//   prev_eq, prev_lt : running state before this digit
//   nxt_eq, nxt_lt   : running state including this digit
module serial_cmp_digit_step #(
    parameter int unsigned DIGIT_W   = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               first,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               prev_eq,
    input  logic               prev_lt,
    output logic               nxt_eq,
    output logic               nxt_lt
);

    logic base_eq;
    logic base_lt;

    // A new word starts from "equal so far".
    assign base_eq = first | prev_eq;
    assign base_lt = ~first & prev_lt;

    always_comb begin
        nxt_eq = base_eq;
        nxt_lt = base_lt;
        if (MSB_FIRST) begin
            // Once a more significant digit differed, the verdict is final.
            if (base_eq) begin
                nxt_eq = (a == b);
                nxt_lt = (a < b);
            end
        end else begin
            // Each more significant differing digit overrides earlier ones.
            if (a != b) begin
                nxt_eq = 1'b0;
                nxt_lt = (a < b);
            end
        end
    end

endmodule : serial_cmp_digit_step

// File: rtl/serial_word_comparator.sv
// Serial comparator of two words A and B delivered DIGIT_W bits per accepted
// beat over WORD_DIGITS beats; one registered lt/eq/gt verdict per word.
// Optional macro SERIAL_WORD_CMP_SIGNED_EN: compare as two's complement.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop the partial word (wins over in_valid)
//   in_valid          : a_digit/b_digit accepted this cycle
//   a_digit, b_digit  : current digits of A and B
//   out_valid         : one-cycle pulse when the verdict updates
//   a_less_b, a_eq_b, a_greater_b : held verdict, exactly one high
module serial_word_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned DIGIT_W     = 2,
    parameter int unsigned WORD_DIGITS = 4,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic               out_valid,
    output logic               a_less_b,
    output logic               a_eq_b,
    output logic               a_greater_b
);

    localparam int unsigned     CNT_W    = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

    cmp_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             run_eq, run_eq_nxt;
    logic             run_lt, run_lt_nxt;
    cmp_flags_t       flags, flags_nxt;
    logic             out_valid_q, out_valid_nxt;

    logic               first;
    logic               last;
    logic [DIGIT_W-1:0] a_step;
    logic [DIGIT_W-1:0] b_step;
    logic               step_eq;
    logic               step_lt;

    assign first = (cnt == '0);
    assign last  = (cnt == LAST_CNT);

`ifdef SERIAL_WORD_CMP_SIGNED_EN
    // Flipping the sign bit of the most significant digit maps two's
    // complement order onto unsigned order.
    logic               msd;
    logic [DIGIT_W-1:0] sign_mask;
    assign msd       = MSB_FIRST ? first : last;
    assign sign_mask = DIGIT_W'(msd) << (DIGIT_W - 1);
    assign a_step    = a_digit ^ sign_mask;
    assign b_step    = b_digit ^ sign_mask;
`else
    assign a_step = a_digit;
    assign b_step = b_digit;
`endif

    serial_cmp_digit_step #(
        .DIGIT_W   (DIGIT_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_step (
        .first   (first),
        .a       (a_step),
        .b       (b_step),
        .prev_eq (run_eq),
        .prev_lt (run_lt),
        .nxt_eq  (step_eq),
        .nxt_lt  (step_lt)
    );

    // State, counter, running compare and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            run_eq      <= 1'b1;
            run_lt      <= 1'b0;
            flags       <= CMP_FLAGS_RESET;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            run_eq      <= run_eq_nxt;
            run_lt      <= run_lt_nxt;
            flags       <= flags_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        run_eq_nxt    = run_eq;
        run_lt_nxt    = run_lt;
        flags_nxt     = flags;
        out_valid_nxt = 1'b0;

        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (in_valid) begin
            run_eq_nxt = step_eq;
            run_lt_nxt = step_lt;
            if (last) begin
                state_nxt     = IDLE;
                cnt_nxt       = '0;
                out_valid_nxt = 1'b1;
                flags_nxt     = '{lt: step_lt, eq: step_eq, gt: ~step_eq & ~step_lt};
            end else begin
                state_nxt = BUSY;
                cnt_nxt   = cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign a_less_b    = flags.lt;
    assign a_eq_b      = flags.eq;
    assign a_greater_b = flags.gt;

endmodule : serial_word_comparator

// File: tb/tb_serial_word_comparator.sv
// Scoreboard bench: u0 MSB-first, u1 LSB-first (2-bit digits, 4 beats),
// u2 single 8-bit digit per word.
module tb_serial_word_comparator;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

`ifdef SERIAL_WORD_CMP_SIGNED_EN
    localparam logic [2:0] SGN_RES = LT;
`else
    localparam logic [2:0] SGN_RES = GT;
`endif

    typedef struct {
        logic [2:0] f;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fl   [3];
    logic       iv   [3];
    logic [1:0] a0, b0, a1, b1;
    logic [7:0] a2, b2;
    logic       ov   [3];
    logic       lt_o [3];
    logic       eq_o [3];
    logic       gt_o [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_word_comparator #(.DIGIT_W(2), .WORD_DIGITS(4), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .a_digit(a0), .b_digit(b0),
        .out_valid(ov[0]), .a_less_b(lt_o[0]), .a_eq_b(eq_o[0]), .a_greater_b(gt_o[0]));

    serial_word_comparator #(.DIGIT_W(2), .WORD_DIGITS(4), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .a_digit(a1), .b_digit(b1),
        .out_valid(ov[1]), .a_less_b(lt_o[1]), .a_eq_b(eq_o[1]), .a_greater_b(gt_o[1]));

    serial_word_comparator #(.DIGIT_W(8), .WORD_DIGITS(1), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .a_digit(a2), .b_digit(b2),
        .out_valid(ov[2]), .a_less_b(lt_o[2]), .a_eq_b(eq_o[2]), .a_greater_b(gt_o[2]));

    function automatic logic [2:0] flags(int i);
        return {lt_o[i], eq_o[i], gt_o[i]};
    endfunction

    task automatic check(string name, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(int i, logic [2:0] f);
        exp_t e;
        e.f   = f;
        e.cyc = cyc + 1;
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // One accepted cycle on instance i; lastd pushes the expected verdict.
    task automatic beat(int i, logic [7:0] a, logic [7:0] b, logic f, logic lastd, logic [2:0] exp);
        case (i)
            0:       begin a0 = a[1:0]; b0 = b[1:0]; end
            1:       begin a1 = a[1:0]; b1 = b[1:0]; end
            default: begin a2 = a;      b2 = b;      end
        endcase
        iv[i] = 1'b1;
        fl[i] = f;
        if (lastd && !f) push(i, exp);
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        fl[i] = 1'b0;
    endtask

    // Full 8-bit word on u0 (MSB first) or u1 (LSB first), optional gaps.
    task automatic send_word(int i, logic [7:0] a, logic [7:0] b, logic [2:0] exp,
                             int gap, logic [2:0] hold);
        for (int d = 0; d < 4; d++) begin
            int idx;
            idx = (i == 0) ? 3 - d : d;
            beat(i, a >> (2 * idx), b >> (2 * idx), 1'b0, d == 3, exp);
            if (d < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    check("gap_hold", int'(flags(i)), int'(hold));
                end
            end
        end
    endtask

    task automatic take(string name, int i, int have, exp_t e);
        if (have == 0) begin
            check({name, "_unexpected_out_valid"}, 1, 0);
        end else begin
            check({name, "_verdict"}, int'(flags(i)), int'(e.f));
            check({name, "_latency"}, cyc, e.cyc);
        end
    endtask

    // Monitor: one-hot invariant and scoreboard pops on out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("onehot_u%0d", i), $countones(flags(i)), 1);
            end
            if (ov[0]) begin
                e = '{f: 3'b0, cyc: 0};
                if (q0.size() != 0) begin e = q0.pop_front(); take("u0", 0, 1, e); end
                else take("u0", 0, 0, e);
            end
            if (ov[1]) begin
                e = '{f: 3'b0, cyc: 0};
                if (q1.size() != 0) begin e = q1.pop_front(); take("u1", 1, 1, e); end
                else take("u1", 1, 0, e);
            end
            if (ov[2]) begin
                e = '{f: 3'b0, cyc: 0};
                if (q2.size() != 0) begin e = q2.pop_front(); take("u2", 2, 1, e); end
                else take("u2", 2, 0, e);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            fl[i] = 1'b0;
            iv[i] = 1'b0;
        end
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_flags_u%0d", i), int'(flags(i)), int'(EQ));
            check($sformatf("reset_out_valid_u%0d", i), int'(ov[i]), 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // MSB-first greater
        send_word(0, 8'hA5, 8'hA3, GT, 0, EQ);
        // LSB-first less, then equal back-to-back
        send_word(1, 8'h35, 8'h53, LT, 0, EQ);
        send_word(1, 8'h7E, 8'h7E, EQ, 0, EQ);
        // Stalled word; verdict from the first word must hold during gaps
        send_word(0, 8'hA5, 8'hA3, GT, 3, GT);
        // Signed vs unsigned ordering, both digit orders
        send_word(0, 8'h80, 8'h01, SGN_RES, 0, EQ);
        send_word(1, 8'h80, 8'h01, SGN_RES, 0, EQ);

        // Flush mid-word (with a digit offered in the same cycle)
        beat(0, 8'h3, 8'h0, 1'b0, 1'b0, EQ);
        beat(0, 8'h3, 8'h0, 1'b0, 1'b0, EQ);
        beat(0, 8'h3, 8'h0, 1'b1, 1'b0, EQ);
        check("flush_held_flags", int'(flags(0)), int'(SGN_RES));
        check("flush_out_valid", int'(ov[0]), 0);
        send_word(0, 8'h10, 8'h10, EQ, 0, EQ);

        // Reset mid-word
        send_word(0, 8'hFF, 8'h00, GT, 0, EQ);
        beat(0, 8'h3, 8'h0, 1'b0, 1'b0, EQ);
        beat(0, 8'h3, 8'h0, 1'b0, 1'b0, EQ);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_flags", int'(flags(0)), int'(EQ));
        check("midreset_out_valid", int'(ov[0]), 0);
        send_word(0, 8'h10, 8'h10, EQ, 0, EQ);

        // Single-digit words on consecutive cycles
        beat(2, 8'd5, 8'd9, 1'b0, 1'b1, LT);
        beat(2, 8'd9, 8'd5, 1'b0, 1'b1, GT);
        beat(2, 8'd7, 8'd7, 1'b0, 1'b1, EQ);

        for (int k = 0; k < 20 && (q0.size() + q1.size() + q2.size()) != 0; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_word_comparator
